// File: rtl/front_panel_scanner.sv
// Row-multiplexed LED matrix scanner with blanking dead-time, global PWM dimming
// and a once-per-frame snapshot of the displayed machine state.
module front_panel_scanner #(
    parameter int ROWS     = 5,
    parameter int COLS     = 8,
    parameter int DIV      = 256,
    parameter int BLANK    = 16,
    parameter int PWM_BITS = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [PWM_BITS-1:0]    brightness,
    input  logic                   lamp_test,
    input  logic [ROWS*COLS-1:0]   row_data,
    output logic                   frame_start,
    output logic [ROWS-1:0]        led_row,
    output logic [COLS-1:0]        led_col
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST   = SW'(DIV - 1);
    localparam logic [SW-1:0] SLOT_BLANK  = SW'(BLANK);
    localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // PWM compare: full-scale brightness must never show a dark sub-slot.
    function automatic logic pwm_lit(input logic [PWM_BITS-1:0] cnt,
                                     input logic [PWM_BITS-1:0] bright);
        return (&bright) | (cnt < bright);
    endfunction

    function automatic logic [COLS-1:0] row_bits(input logic [ROWS*COLS-1:0] flat,
                                                 input logic [RW-1:0]        r);
        logic [COLS-1:0] res;
        res = {COLS{1'b0}};
        for (int i = 0; i < ROWS; i++) begin
            if (r == RW'(i)) begin
                res = flat[i*COLS +: COLS];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [1:0]            rst_sync_q;
    logic                  rst_n_s;
    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [PWM_BITS-1:0]   pwm_q, pwm_d;
    logic [ROWS*COLS-1:0]  shadow_q, shadow_d;
    logic                  frame_start_q, frame_start_d;
    logic [ROWS-1:0]       led_row_q, led_row_d;
    logic [COLS-1:0]       led_col_q, led_col_d;
    logic                  on_phase_s;

    // Reset synchronizer: asserts asynchronously, releases on clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s    = rst_sync_q[1];
    assign on_phase_s = (state_q == ST_SCAN) && (slot_q >= SLOT_BLANK);

    // Next-state logic for scan position, PWM phase and frame snapshot.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        slot_d        = slot_q;
        pwm_d         = pwm_q;
        shadow_d      = shadow_q;
        frame_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                row_d  = {RW{1'b0}};
                slot_d = {SW{1'b0}};
                pwm_d  = {PWM_BITS{1'b0}};
                if (enable) begin
                    state_d       = ST_SCAN;
                    shadow_d      = row_data;
                    frame_start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    row_d   = {RW{1'b0}};
                    slot_d  = {SW{1'b0}};
                    pwm_d   = {PWM_BITS{1'b0}};
                end else begin
                    if (slot_q == SLOT_LAST) begin
                        slot_d = {SW{1'b0}};
                        if (row_q == ROW_LAST) begin
                            row_d         = {RW{1'b0}};
                            shadow_d      = row_data;
                            frame_start_d = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                    // Hold PWM at zero through blanking so each on phase starts at 0.
                    if (on_phase_s && (slot_q != SLOT_LAST)) begin
                        pwm_d = pwm_q + 1'b1;
                    end else begin
                        pwm_d = {PWM_BITS{1'b0}};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                row_d   = {RW{1'b0}};
                slot_d  = {SW{1'b0}};
                pwm_d   = {PWM_BITS{1'b0}};
            end
        endcase
    end

    // Output decode from the current scan position; registered below.
    always_comb begin
        led_row_d = {ROWS{1'b0}};
        led_col_d = {COLS{1'b1}};
        if (on_phase_s) begin
            led_row_d = ROWS'(1) << row_q;
            if (pwm_lit(pwm_q, brightness)) begin
                led_col_d = lamp_test ? {COLS{1'b0}} : ~row_bits(shadow_q, row_q);
            end else begin
                led_col_d = {COLS{1'b1}};
            end
        end else begin
            led_row_d = {ROWS{1'b0}};
            led_col_d = {COLS{1'b1}};
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q  <= ST_IDLE;
            row_q    <= {RW{1'b0}};
            slot_q   <= {SW{1'b0}};
            pwm_q    <= {PWM_BITS{1'b0}};
            shadow_q <= {(ROWS*COLS){1'b0}};
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            slot_q   <= slot_d;
            pwm_q    <= pwm_d;
            shadow_q <= shadow_d;
        end
    end

    // Output registers; reset drives the panel dark immediately.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            frame_start_q <= 1'b0;
            led_row_q     <= {ROWS{1'b0}};
            led_col_q     <= {COLS{1'b1}};
        end else begin
            frame_start_q <= frame_start_d;
            led_row_q     <= led_row_d;
            led_col_q     <= led_col_d;
        end
    end

    assign frame_start = frame_start_q;
    assign led_row     = led_row_q;
    assign led_col     = led_col_q;

endmodule

// File: tb/tb_front_panel_scanner.sv
// Directed bench for front_panel_scanner: a cycle model of the scan sequence
// predicts led_row/led_col/frame_start one clock behind the scan position.
module tb_front_panel_scanner;

    localparam int ROWS  = 5;
    localparam int COLS  = 8;
    localparam int DIV   = 16;
    localparam int BLANK = 4;
    localparam int PB    = 2;
    localparam int FRAME = ROWS * DIV;

    logic              clk = 1'b0;
    logic              resetn;
    logic              enable;
    logic [PB-1:0]     brightness;
    logic              lamp_test;
    logic [ROWS*COLS-1:0] row_data;
    logic              frame_start;
    logic [ROWS-1:0]   led_row;
    logic [COLS-1:0]   led_col;

    int errors = 0;
    int checks = 0;
    int n = 0;
    logic [COLS-1:0] mshadow [ROWS];

    front_panel_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK), .PWM_BITS(PB)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .brightness(brightness),
        .lamp_test(lamp_test), .row_data(row_data), .frame_start(frame_start),
        .led_row(led_row), .led_col(led_col)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s n=%0d: got %0h expected %0h", tag, n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_shadow();
        for (int r = 0; r < ROWS; r++) mshadow[r] = row_data[r*COLS +: COLS];
    endtask

    // Output seen at cycle n reflects scan position g = n-1 since frame start.
    task automatic check_model();
        int g, slot, row, pwm;
        logic [ROWS-1:0] er;
        logic [COLS-1:0] ec;
        logic lit;
        g  = n - 1;
        er = 5'b00000;
        ec = 8'hFF;
        if (g >= 0) begin
            slot = g % DIV;
            row  = (g / DIV) % ROWS;
            if (slot >= BLANK) begin
                pwm = (slot - BLANK) % (1 << PB);
                er  = 5'b00001 << row;
                lit = (brightness == 2'd3) || (pwm < brightness);
                if (lit) ec = lamp_test ? 8'h00 : ~mshadow[row];
            end
        end
        check_eq("led_row", led_row, er);
        check_eq("led_col", led_col, ec);
        check_eq("frame_start", frame_start, (n % FRAME == 0) ? 1 : 0);
    endtask

    task automatic run(input int k);
        repeat (k) begin
            tick();
            n++;
            check_model();
            if (n % FRAME == 0) load_shadow();
        end
    endtask

    task automatic restart();
        enable = 1'b1;
        tick();
        n = 0;
        load_shadow();
        check_eq("restart_fs", frame_start, 1);
        check_eq("restart_row", led_row, 5'b00000);
        check_eq("restart_col", led_col, 8'hFF);
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0; lamp_test = 1'b0;
        brightness = 2'd0; row_data = 40'h0;
        repeat (2) tick();
        check_eq("reset_row", led_row, 5'b00000);
        check_eq("reset_col", led_col, 8'hFF);
        check_eq("reset_fs", frame_start, 0);
        resetn = 1'b1;

        // Idle with enable low: panel dark, no frame pulses.
        repeat (200) begin
            tick();
            check_eq("idle_row", led_row, 5'b00000);
            check_eq("idle_col", led_col, 8'hFF);
            check_eq("idle_fs", frame_start, 0);
        end

        brightness = 2'd3;
        row_data   = {8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        restart();
        run(2 * FRAME);

        // Dim to 1/4 with a fully lit row 0 (visible from the next frame).
        brightness     = 2'd1;
        row_data[7:0]  = 8'hFF;
        run(2 * FRAME);
        brightness = 2'd0;
        run(FRAME);

        // Mid-frame data change stays hidden until the next snapshot.
        brightness = 2'd3;
        run(40);
        row_data = {8'hAA, 8'h55, 8'hF0, 8'h0F, 8'h81};
        run(120);

        lamp_test = 1'b1;
        row_data  = 40'h0;
        run(FRAME + 40);

        // Drop enable during row 2 on phase.
        enable = 1'b0;
        tick();
        check_eq("dis1_row", led_row, 5'b00100);
        check_eq("dis1_col", led_col, 8'h00);
        tick();
        check_eq("dis2_row", led_row, 5'b00000);
        check_eq("dis2_col", led_col, 8'hFF);
        tick();
        check_eq("dis3_fs", frame_start, 0);

        lamp_test = 1'b0;
        row_data  = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        restart();
        run(DIV + 10);
        run(16);

        // Asynchronous reset between clock edges.
        #3;
        resetn = 1'b0;
        #1;
        check_eq("areset_row", led_row, 5'b00000);
        check_eq("areset_col", led_col, 8'hFF);
        check_eq("areset_fs", frame_start, 0);
        enable = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (4) begin
            tick();
            check_eq("post_rst_row", led_row, 5'b00000);
            check_eq("post_rst_col", led_col, 8'hFF);
        end
        restart();
        run(FRAME + 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
